// File: rtl/fb_scan_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_scan_arbiter_pkg
// Description : Shared frame-buffer geometry constants and the pixel-address
//               helper used by the scan arbiter and its read pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_scan_arbiter_pkg;

   localparam int H_RES        = 640;
   localparam int V_RES        = 480;
   localparam int FRAME_PIXELS = H_RES * V_RES;   // 307200
   localparam int COLOR_W      = 3;
   localparam int ADDR_W       = 19;
   localparam int X_W          = 10;
   localparam int Y_W          = 9;

   // Linear pixel address for a 640-wide frame: y*640 = y*512 + y*128.
   // Shift/add form keeps the datapath free of a general multiplier.
   function automatic logic [ADDR_W-1:0] pixel_addr(
      input logic [X_W-1:0] x,
      input logic [Y_W-1:0] y
   );
      return {1'b0, y, 9'd0} + {3'd0, y, 7'd0} + {9'd0, x};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fb_read_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fb_read_pipe
// Description : Delays the scanout-issue valid by the memory read latency,
//               captures the returned colour and produces the FIFO push.
//               Issue at cycle N -> push visible at N+2+MEM_RD_LAT.
// Ports       : clk, rst_n         clock / synchronous active-low reset
//               i_issue            scanout grant (combinational, cycle N)
//               i_mem_rdata        memory read data
//               o_color / o_push   colour and push strobe toward the FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module fb_read_pipe
   import fb_scan_arbiter_pkg::*;
#(
   parameter int MEM_RD_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_issue,
   input  logic [COLOR_W-1:0] i_mem_rdata,
   output logic [COLOR_W-1:0] o_color,
   output logic               o_push
);

   // r_vld[0] is the address-phase cycle; r_vld[MEM_RD_LAT] is the cycle in
   // which mem_rdata belongs to that read.
   logic [MEM_RD_LAT:0] r_vld;
   logic [COLOR_W-1:0]  r_color;
   logic                r_push;

   generate
      if (MEM_RD_LAT == 0) begin : g_lat0
         always_ff @(posedge clk) begin
            if (!rst_n) r_vld <= '0;
            else        r_vld <= i_issue;
         end
      end else begin : g_latn
         always_ff @(posedge clk) begin
            if (!rst_n) r_vld <= '0;
            else        r_vld <= {r_vld[MEM_RD_LAT-1:0], i_issue};
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_color <= '0;
         r_push  <= 1'b0;
      end else begin
         r_push <= r_vld[MEM_RD_LAT];
         if (r_vld[MEM_RD_LAT]) r_color <= i_mem_rdata;
      end
   end

   assign o_color = r_color;
   assign o_push  = r_push;

endmodule
`default_nettype wire

// File: rtl/fb_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_scan_arbiter
// Description : Shares a single-port frame buffer between rasterizer writes
//               (back bank) and display scanout reads (front bank). Banks
//               swap only at the end-of-frame scanout grant.
// Ports       : clk, rst_n                 clock / sync active-low reset
//               next_frame_switch          bank swap request (latched)
//               rast_pixel_rdy/_color_input/_width/_height  pixel write req
//               read_rast_pixel_rdy        write accept (combinational)
//               dvi_fifo_full              FIFO almost-full
//               dvi_color_out/dvi_fifo_write_enable  scanout push
//               mem_addr/mem_we/mem_wdata/mem_rdata  memory port
//               front_bank                 bank being scanned out
// Revision    : 1.0 - initial release
// ============================================================================
module fb_scan_arbiter #(
   parameter int H_RES      = fb_scan_arbiter_pkg::H_RES,
   parameter int V_RES      = fb_scan_arbiter_pkg::V_RES,
   parameter int MEM_RD_LAT = 1,
   parameter int STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        next_frame_switch,
   input  logic        rast_pixel_rdy,
   input  logic [2:0]  rast_color_input,
   input  logic [9:0]  rast_width,
   input  logic [8:0]  rast_height,
   output logic        read_rast_pixel_rdy,
   input  logic        dvi_fifo_full,
   output logic [2:0]  dvi_color_out,
   output logic        dvi_fifo_write_enable,
   output logic [19:0] mem_addr,
   output logic        mem_we,
   output logic [2:0]  mem_wdata,
   input  logic [2:0]  mem_rdata,
   output logic        front_bank
);

   import fb_scan_arbiter_pkg::*;

   localparam int                C_FRAME      = H_RES * V_RES;
   localparam int                C_CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W-1:0] C_LAST_PIX   = ADDR_W'(C_FRAME - 1);
   localparam logic [X_W-1:0]    C_X_LIM      = X_W'(H_RES);
   localparam logic [Y_W-1:0]    C_Y_LIM      = Y_W'(V_RES);
   localparam logic [C_CNT_W-1:0] C_STARVE_LIM = C_CNT_W'(STARVE_MAX);

   logic                r_front_bank;
   logic                r_swap_pending;
   logic [ADDR_W-1:0]   r_scan_addr;
   logic [C_CNT_W-1:0]  r_starve;
   logic [ADDR_W:0]     r_mem_addr;
   logic                r_mem_we;
   logic [COLOR_W-1:0]  r_mem_wdata;

   logic                w_wr_grant;
   logic                w_scan_grant;
   logic                w_in_range;
   logic                w_last_pix;
   logic                w_swap;
   logic [ADDR_W-1:0]   w_pix_addr;

   // Scanout wins unless the writer has already been passed over STARVE_MAX
   // times in a row; a write also wins whenever scanout is blocked.
   assign w_wr_grant   = rast_pixel_rdy && ((r_starve == C_STARVE_LIM) || dvi_fifo_full);
   assign w_scan_grant = !dvi_fifo_full && !w_wr_grant;
   assign w_in_range   = (rast_width < C_X_LIM) && (rast_height < C_Y_LIM);
   assign w_last_pix   = (r_scan_addr == C_LAST_PIX);
   // A switch raised in the very cycle of the last grant still counts.
   assign w_swap       = w_scan_grant && w_last_pix && (r_swap_pending || next_frame_switch);

   generate
      if (H_RES == 640) begin : g_addr_640
         assign w_pix_addr = pixel_addr(rast_width, rast_height);
      end else begin : g_addr_gen
         assign w_pix_addr = ADDR_W'(rast_height) * ADDR_W'(H_RES) + ADDR_W'(rast_width);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_front_bank   <= 1'b0;
         r_swap_pending <= 1'b0;
         r_scan_addr    <= '0;
         r_starve       <= '0;
         r_mem_addr     <= '0;
         r_mem_we       <= 1'b0;
         r_mem_wdata    <= '0;
      end else begin
         r_mem_we <= 1'b0;
         if (w_scan_grant) begin
            r_mem_addr  <= {r_front_bank, r_scan_addr};
            r_scan_addr <= w_last_pix ? '0 : r_scan_addr + 1'b1;
         end else if (w_wr_grant && w_in_range) begin
            r_mem_addr  <= {~r_front_bank, w_pix_addr};
            r_mem_we    <= 1'b1;
            r_mem_wdata <= rast_color_input;
         end
         // Out-of-range writes and idle cycles leave the address untouched.

         if (w_swap) begin
            r_front_bank   <= ~r_front_bank;
            r_swap_pending <= 1'b0;
         end else if (next_frame_switch) begin
            r_swap_pending <= 1'b1;
         end

         if (w_scan_grant && rast_pixel_rdy) begin
            r_starve <= r_starve + 1'b1;
         end else if (w_wr_grant || !rast_pixel_rdy) begin
            r_starve <= '0;
         end
      end
   end

   fb_read_pipe #(
      .MEM_RD_LAT (MEM_RD_LAT)
   ) u_read_pipe (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_issue     (w_scan_grant),
      .i_mem_rdata (mem_rdata),
      .o_color     (dvi_color_out),
      .o_push      (dvi_fifo_write_enable)
   );

   assign read_rast_pixel_rdy = w_wr_grant;
   assign mem_addr            = r_mem_addr;
   assign mem_we              = r_mem_we;
   assign mem_wdata           = r_mem_wdata;
   assign front_bank          = r_front_bank;

endmodule
`default_nettype wire
